// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit
// Pipelined add/subtract unit. Operands are cut into SLICE-bit slices and one
// slice is resolved per stage, with the slice carry registered between stages.
// Every stage advances together under a single global advance term, so the
// pipeline behaves like a fixed-latency shift register with valid/ready on
// both ends.
//
// WIDTH must be an integer multiple of SLICE. STAGES = WIDTH / SLICE (>= 1).

module adder_pipe_nbit #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int LAST   = STAGES - 1;

  // ---------------------------------------------------------------------------
  // Pipeline state.
  //   a_q/b_q   : operand A and effective operand B' travelling with the beat;
  //               only the slices above the stage index are still consumed.
  //   sum_q     : result slices completed so far (slices 0..k valid at stage k).
  //   carry_q   : carry out of the slice resolved in stage k.
  //   valid_q   : stage occupancy.
  //   ovf_q     : overflow flag of the beat sitting in the last stage.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q;
  logic              ovf_d;

  // Global advance: the whole pipe moves unless the output beat is blocked.
  logic adv;

  // Effective operands for the incoming beat. Subtraction is a + ~b + ~c_in.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // What each stage would load from its predecessor (stage 0 loads the input).
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  // Slice arithmetic scratch for the per-stage adders.
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE:0]   slice_r;

  // Separate view of the last stage's slice, used only for the overflow flag.
  logic [SLICE-1:0] last_a;
  logic [SLICE-1:0] last_b;
  logic [SLICE:0]   last_r;

  // Handshake: accept whenever the pipe can shift; no bubble collapsing.
  always_comb begin
    adv      = (~valid_q[LAST]) | out_ready;
    in_ready = adv;
  end

  // Operand conditioning for add versus subtract.
  always_comb begin
    if (sub) begin
      b_eff = ~b;
    end else begin
      b_eff = b;
    end
    c_eff = c_in ^ sub;
  end

  // Stage input wiring: stage 0 takes the input beat, later stages their predecessor.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign src_a[k]   = a;
      assign src_b[k]   = b_eff;
      assign src_sum[k] = {WIDTH{1'b0}};
      assign src_c[k]   = c_eff;
      assign src_v[k]   = in_valid;
    end else begin : g_next
      assign src_a[k]   = a_q[k-1];
      assign src_b[k]   = b_q[k-1];
      assign src_sum[k] = sum_q[k-1];
      assign src_c[k]   = carry_q[k-1];
      assign src_v[k]   = valid_q[k-1];
    end
  end

  // Per-stage next state: resolve slice k on advance, otherwise hold.
  // Data registers only load when a real beat arrives so the outputs keep
  // their last values while bubbles pass through.
  always_comb begin
    slice_a = {SLICE{1'b0}};
    slice_b = {SLICE{1'b0}};
    slice_r = {(SLICE+1){1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      slice_a = src_a[k][k*SLICE +: SLICE];
      slice_b = src_b[k][k*SLICE +: SLICE];
      slice_r = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, src_c[k]};

      if (adv && src_v[k]) begin
        a_d[k]                      = src_a[k];
        b_d[k]                      = src_b[k];
        sum_d[k]                    = src_sum[k];
        sum_d[k][k*SLICE +: SLICE]  = slice_r[SLICE-1:0];
        carry_d[k]                  = slice_r[SLICE];
      end else begin
        a_d[k]     = a_q[k];
        b_d[k]     = b_q[k];
        sum_d[k]   = sum_q[k];
        carry_d[k] = carry_q[k];
      end

      if (adv) begin
        valid_d[k] = src_v[k];
      end else begin
        valid_d[k] = valid_q[k];
      end
    end
  end

  // Overflow of the last slice: carry into its MSB (recovered from the MSB
  // sum bit and the operand MSBs) XOR carry out of the MSB.
  always_comb begin
    last_a = src_a[LAST][LAST*SLICE +: SLICE];
    last_b = src_b[LAST][LAST*SLICE +: SLICE];
    last_r = {1'b0, last_a} + {1'b0, last_b} + {{SLICE{1'b0}}, src_c[LAST]};
    if (adv && src_v[LAST]) begin
      ovf_d = last_r[SLICE] ^ (last_r[SLICE-1] ^ last_a[SLICE-1] ^ last_b[SLICE-1]);
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pipeline registers; asynchronous reset flushes every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {STAGES{1'b0}};
      carry_q <= {STAGES{1'b0}};
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        sum_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  // Result port: straight from the last stage's registers.
  always_comb begin
    out_valid = valid_q[LAST];
    sum       = sum_q[LAST];
    c_out     = carry_q[LAST];
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// tb_adder_pipe_nbit
// Self-checking bench: a 16/4 instance driven with directed and random beats
// against an integer-arithmetic reference queue, plus an 8/8 single-stage
// instance for the one-cycle latency case.

module tb_adder_pipe_nbit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        out_valid8;
  logic [7:0]  sum8;
  logic        c_out8;
  logic        ovf8;

  int checks   = 0;
  int failures = 0;

  logic [17:0] exp_q[$];
  logic [17:0] e;

  adder_pipe_nbit #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  adder_pipe_nbit #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c_in(1'b0), .sub(1'b0),
    .out_valid(out_valid8), .out_ready(1'b1),
    .sum(sum8), .c_out(c_out8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, c_out, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_result(input logic [15:0] fa, input logic [15:0] fb,
                                             input logic fc, input logic fs);
    int u;
    int r;
    logic co;
    logic ov;
    if (!fs) begin
      u  = int'(fa) + int'(fb) + int'(fc);
      co = (u > 65535);
      r  = int'($signed(fa)) + int'($signed(fb)) + int'(fc);
    end else begin
      u  = int'(fa) - int'(fb) - int'(fc);
      co = (u >= 0);
      r  = int'($signed(fa)) - int'($signed(fb)) - int'(fc);
    end
    ov = (r > 32767) || (r < -32768);
    return {ov, co, u[15:0]};
  endfunction

  // Scoreboard: handshakes are judged at the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_sum", 32'(sum), 32'(e[15:0]));
          check_eq("sb_cout", 32'(c_out), 32'(e[16]));
          check_eq("sb_ovf", 32'(ovf), 32'(e[17]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_result(a, b, c_in, sub));
      end
    end
  end

  // In-flight beats are discarded by reset.
  always @(negedge rst_n) begin
    exp_q.delete();
  end

  task automatic wait_empty();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send_dir(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                          input logic ts, input logic [15:0] es, input logic eco, input logic eov);
    int n = 0;
    wait_empty();
    @(posedge clk); #1;
    a = ta; b = tbv; c_in = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 32'(n), 32'd3);
    check_eq("dir_sum", 32'(sum), 32'(es));
    check_eq("dir_cout", 32'(c_out), 32'(eco));
    check_eq("dir_ovf", 32'(ovf), 32'(eov));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0000; b = 16'h0000; c_in = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;

    // Reset held for 3 cycles; out_ready low so in_ready must come from out_valid=0.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_sum", 32'(sum), 32'd0);
      check_eq("rst_cout", 32'(c_out), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
      check_eq("rst_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Directed vectors.
    send_dir(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    send_dir(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_dir(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

    // Random back-to-back stream with a 3-cycle consumer stall.
    wait_empty();
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          a = 16'($urandom); b = 16'($urandom);
          c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          wait_ready();
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        int n = 0;
        logic [15:0] cap_sum;
        logic cap_co;
        logic cap_ov;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        cap_sum = sum; cap_co = c_out; cap_ov = ovf;
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_ready", 32'(in_ready), 32'd0);
          check_eq("stall_hold_valid", 32'(out_valid), 32'd1);
          check_eq("stall_hold_sum", 32'(sum), 32'(cap_sum));
          check_eq("stall_hold_cout", 32'(c_out), 32'(cap_co));
          check_eq("stall_hold_ovf", 32'(ovf), 32'(cap_ov));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_empty();

    // Asynchronous reset with 3 beats in flight (first one blocked at the output).
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); c_in = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_sum", 32'(sum), 32'd0);
    check_eq("async_rst_cout", 32'(c_out), 32'd0);
    check_eq("async_rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check_eq("no_ghost", 32'(out_valid), 32'd0);
    end

    // Single-stage instance: result valid one edge after acceptance.
    @(posedge clk); #1;
    a8 = 8'h01; b8 = 8'h01; in_valid8 = 1'b1;
    @(negedge clk);
    check_eq("s1_ready", 32'(in_ready8), 32'd1);
    check_eq("s1_pre_valid", 32'(out_valid8), 32'd0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check_eq("s1_valid", 32'(out_valid8), 32'd1);
    check_eq("s1_sum", 32'(sum8), 32'h02);
    check_eq("s1_cout", 32'(c_out8), 32'd0);
    check_eq("s1_ovf", 32'(ovf8), 32'd0);
    @(posedge clk); #1;
    check_eq("s1_drained", 32'(out_valid8), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_pipe_nbit.md
# adder_pipe_nbit

Parametrised, pipelined add/subtract unit: the multi-stage successor to the 4-bit ripple adder. Operands are split into SLICE-bit slices, with one slice resolved per pipeline stage and the carry registered between stages. This lets wide adders close timing at one result per cycle. It sits between an upstream operand source and a downstream consumer, with a valid/ready handshake on both sides.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of SLICE.
- SLICE, 4: bits resolved per stage. Derived STAGES = WIDTH/SLICE, which is ≥1.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in when adding; borrow-in when subtracting.
- sub  in  1  0: a+b+c_in; 1: a−b−c_in.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  carry out of the MSB. When subtracting, 1 means no borrow.
- ovf  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

## Operation
- Effective operands: B' = sub ? ~b : b; carry-in' = sub ? ~c_in : c_in.
  - Add result: {c_out,sum} = a + b + c_in.
  - Subtract result: a + ~b + ~c_in = a − b − c_in.
- Stage k (0..STAGES−1) adds slice k of A and B' plus the carry registered from stage k−1 (stage 0 uses carry-in'). It registers the slice sum and the carry out.
- Unprocessed upper slices of A and B' travel with the beat. Completed lower slices also travel with it. Only remaining slices need to be carried.
- The last stage also registers the carry into its slice MSB, for ovf.
- Each stage holds a valid bit. out_valid is the valid bit of the last stage.
- Global advance: adv = !out_valid || out_ready. When adv=1, every stage loads from its predecessor and stage 0 loads the input beat. When adv=0, all stages hold.
- in_ready = adv, combinational. An input is accepted when in_valid && in_ready.
- Bubbles are not collapsed: an empty stage still moves only on adv.
- Beats leave in acceptance order, with no loss and no duplication.

## Timing
- Reset (rst_n=0): all valid bits are 0. sum, c_out, ovf and all pipeline data are 0. in_ready=1 whenever out_valid=0.
- Reset asserted mid-operation discards all in-flight beats immediately, regardless of clock. Outputs return to reset values.
- Latency: a beat accepted at edge E is registered into the last stage at edge E+STAGES−1, with no stall. out_valid is high from then on.
  - STAGES=1 gives the result in the cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 drives in_ready low. sum, c_out, ovf and out_valid stay stable until the beat is taken.
- Simultaneous pop and push in the same cycle is legal, and the pipeline advances by one.
- When out_valid=0, sum, c_out and ovf hold their last values. The consumer must ignore them.
- Inputs a, b, c_in and sub are sampled only on acceptance. Values outside acceptance are don't-care.

## Test plan
Default parameters WIDTH=16, SLICE=4 (STAGES=4) unless stated.

- **Reset:** rst_n=0 for 3 cycles, then release. Required: out_valid=0, sum=0x0000, c_out=0, ovf=0, in_ready=1 both during and after reset.
- **Basic add:** a=0x0001, b=0x0001, c_in=0, sub=0, accepted at edge E. Required: out_valid rises after edge E+3, with sum=0x0002, c_out=0, ovf=0.
- **Full-width carry ripple:** a=0xFFFF, b=0x0000, c_in=1. Required: sum=0x0000, c_out=1, ovf=0. Then a=0x7FFF, b=0x0001, c_in=0. Required: sum=0x8000, c_out=0, ovf=1.
- **Subtract:**
  - a=0x0005, b=0x0007, c_in=0, sub=1 → sum=0xFFFE, c_out=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, c_out=1, ovf=1.
  - a=0x0010, b=0x0003, c_in=1, sub=1 → sum=0x000C.
- **Back-pressure stream:** 10 back-to-back random beats with in_valid=1. Hold out_ready=0 for 3 cycles while out_valid=1. Required:
  - in_ready=0 during the stall;
  - outputs held stable during the stall;
  - all 10 results match the scoreboard, in order, with no duplicates.
- **Reset mid-stream, plus STAGES=1:** assert rst_n=0 asynchronously with 3 beats in flight. Required: out_valid drops immediately and none of those beats is ever emitted. Repeat the basic add with WIDTH=8, SLICE=8. Required: result valid one edge after acceptance.
